// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
// Frame-level controller in front of the WS2812 single-wire bit transmitter.
// A frame request fetches Num_Leds 24-bit GRB words from a pixel buffer and
// feeds them MSB-first, one bit per transmitter handshake. After the last bit
// it requests the reset/latch period, then releases the transmitter and
// pulses Frame_Done.
//
// Ports:
//   Clock, cRst_n          system clock, asynchronous active-low reset
//   Frame_Start, Num_Leds  frame request and LED count (sampled from IDLE only)
//   Busy, Frame_Done       status: busy outside IDLE, one-cycle completion pulse
//   Pix_Rd, Pix_Addr       pixel read strobe and index
//   Pix_Data               read data, valid one cycle after Pix_Rd
//   Begin_Tran_Flag, DI, RGB_Data_Rst_Req   registered controls to transmitter
//   OneBit_Tram_Ok         transmitter re-entered bit check (sample point)
//   RGB_Data_Rst_Tram_Ok   transmitter finished the reset/latch period
module ws2812_frame_sequencer #(
  parameter int LED_AW = 8,
  parameter int PIX_W  = 24
) (
  input  logic              Clock,
  input  logic              cRst_n,
  input  logic              Frame_Start,
  input  logic [LED_AW-1:0] Num_Leds,
  output logic              Busy,
  output logic              Frame_Done,
  output logic              Pix_Rd,
  output logic [LED_AW-1:0] Pix_Addr,
  input  logic [PIX_W-1:0]  Pix_Data,
  output logic              Begin_Tran_Flag,
  output logic              DI,
  output logic              RGB_Data_Rst_Req,
  input  logic              OneBit_Tram_Ok,
  input  logic              RGB_Data_Rst_Tram_Ok
);

  localparam int BCW = $clog2(PIX_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_ARM, S_FIRST, S_SHIFT, S_LATCH, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PIX_W-1:0]  shift_reg;
  logic [PIX_W-1:0]  next_word;
  logic [BCW-1:0]    bit_cnt;
  logic [LED_AW-1:0] pixels_left;
  logic [LED_AW-1:0] pix_addr;
  logic              pf_rd;
  logic              pf_cap;
  logic              rst_req;
  logic              begin_flag;
  logic              accept;
  logic              advance;

  assign accept  = (state == S_IDLE) && Frame_Start;
  // Sample events: the first bit check (FIRST) and every OneBit_Tram_Ok in
  // SHIFT. Once the latch request is out, further handshakes are not bits.
  assign advance = (state == S_FIRST) ||
                   ((state == S_SHIFT) && OneBit_Tram_Ok && !rst_req);

  always_ff @(posedge Clock or negedge cRst_n) begin
    if (!cRst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (Frame_Start) state_nxt = (Num_Leds == '0) ? S_ARM : S_FETCH;
      S_FETCH: state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_ARM;
      S_ARM:   state_nxt = S_FIRST;
      S_FIRST: state_nxt = S_SHIFT;
      S_SHIFT: if (rst_req) state_nxt = S_LATCH;
      S_LATCH: if (RGB_Data_Rst_Tram_Ok) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy             = (state != S_IDLE);
    Frame_Done       = (state == S_DONE);
    Pix_Rd           = (state == S_FETCH) || pf_rd;
    Pix_Addr         = pix_addr;
    DI               = shift_reg[PIX_W-1];
    RGB_Data_Rst_Req = rst_req;
    Begin_Tran_Flag  = begin_flag;
  end

  // DI is the MSB of the shift register, so clearing the register after the
  // last bit is what returns DI to 0.
  always_ff @(posedge Clock or negedge cRst_n) begin
    if (!cRst_n) begin
      shift_reg   <= '0;
      next_word   <= '0;
      bit_cnt     <= '0;
      pixels_left <= '0;
      pix_addr    <= '0;
      pf_rd       <= 1'b0;
      pf_cap      <= 1'b0;
      rst_req     <= 1'b0;
      begin_flag  <= 1'b0;
    end else begin
      pf_rd  <= 1'b0;
      pf_cap <= pf_rd;
      if (pf_cap) next_word <= Pix_Data;

      if (accept) begin
        pixels_left <= Num_Leds;
        pix_addr    <= '0;
        shift_reg   <= '0;
        bit_cnt     <= '0;
        rst_req     <= (Num_Leds == '0);
      end

      if (state == S_CAPT) begin
        shift_reg   <= Pix_Data;
        bit_cnt     <= BCW'(PIX_W - 1);
        pixels_left <= pixels_left - LED_AW'(1);
        if (pixels_left > LED_AW'(1)) begin
          pf_rd    <= 1'b1;
          pix_addr <= pix_addr + LED_AW'(1);
        end
      end

      if (advance) begin
        if (bit_cnt != '0) begin
          shift_reg <= {shift_reg[PIX_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt - BCW'(1);
        end else if (pixels_left != '0) begin
          // Underflow just reuses whatever the prefetch register holds.
          shift_reg   <= next_word;
          bit_cnt     <= BCW'(PIX_W - 1);
          pixels_left <= pixels_left - LED_AW'(1);
          if (pixels_left > LED_AW'(1)) begin
            pf_rd    <= 1'b1;
            pix_addr <= pix_addr + LED_AW'(1);
          end
        end else begin
          shift_reg <= '0;
          rst_req   <= 1'b1;
        end
      end

      if (state_nxt == S_ARM && state != S_ARM) begin_flag <= 1'b1;

      if (state == S_LATCH && RGB_Data_Rst_Tram_Ok) begin
        begin_flag <= 1'b0;
        rst_req    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Frame-level controller for the WS2812 single-wire bit transmitter.
- On a frame request it fetches Num_Leds 24-bit GRB pixel words from a pixel buffer, one word per LED.
- It feeds the words MSB-first, one bit per transmitter handshake.
- After the last bit it requests the reset/latch period, then returns the transmitter to its idle state and reports completion.

Parameters:
- LED_AW, 8, width of the LED count and of the pixel address (max 2^LED_AW-1 LEDs).
- PIX_W, 24, bits per pixel word, sent MSB first (G7..G0, R7..R0, B7..B0).

Ports:
- Clock  in  1  system clock.
- cRst_n  in  1  asynchronous active-low reset.
- Frame_Start  in  1  single-cycle frame request; ignored while Busy=1.
- Num_Leds  in  LED_AW  LED count, sampled on an accepted Frame_Start.
- Busy  out  1  high from the cycle after an accepted Frame_Start until Frame_Done.
- Frame_Done  out  1  one-cycle pulse when the frame and latch period are complete.
- Pix_Rd  out  1  one-cycle pixel read strobe.
- Pix_Addr  out  LED_AW  pixel index for Pix_Rd; counts from 0.
- Pix_Data  in  PIX_W  read data, valid exactly 1 cycle after Pix_Rd.
- Begin_Tran_Flag  out  1  to transmitter: start and hold the bit session.
- DI  out  1  to transmitter: current bit value.
- RGB_Data_Rst_Req  out  1  to transmitter: next bit slot is the reset/latch period.
- OneBit_Tram_Ok  in  1  from transmitter: one-cycle pulse on re-entry to bit check. The transmitter samples DI and RGB_Data_Rst_Req in that same cycle.
- RGB_Data_Rst_Tram_Ok  in  1  from transmitter: reset/latch period finished.

Behaviour:
- Reset (async): every output is 0, the FSM is in IDLE, and all counters and registers are 0.
- DI, RGB_Data_Rst_Req and Begin_Tran_Flag are registered outputs.
- Sample event: the transmitter samples DI/RGB_Data_Rst_Req at two kinds of points:
  - in the cycle after Begin_Tran_Flag first rises (first bit check);
  - in each OneBit_Tram_Ok cycle.
- On the edge ending a sample event, the sequencer advances DI to the next bit, or sets RGB_Data_Rst_Req after the last bit.
- FSM states:
  - IDLE: on Frame_Start, latch Num_Leds into the LED counter. If Num_Leds=0, go to ARM with RGB_Data_Rst_Req=1. Otherwise go to FETCH.
  - FETCH: Pix_Rd=1 with Pix_Addr=0 for 1 cycle, then go to CAPT.
  - CAPT: load Pix_Data into the shift register, set DI to its MSB, set bit_cnt=PIX_W-1, and go to ARM.
  - ARM: Begin_Tran_Flag=1 for 1 cycle, then go to FIRST.
  - FIRST: this cycle is the first sample event; go to SHIFT and advance.
  - SHIFT:
    - On OneBit_Tram_Ok, advance.
    - If RGB_Data_Rst_Req is already 1, go to LATCH (the transmitter has entered RET).
  - LATCH: wait for RGB_Data_Rst_Tram_Ok, then clear Begin_Tran_Flag and RGB_Data_Rst_Req and go to DONE.
  - DONE: 1 cycle with Frame_Done=1 and Busy=0 next, then go to IDLE.
- Advance rule:
  - If bit_cnt>0: shift left, DI=new MSB, bit_cnt-1.
  - Else if pixels remain: load the prefetch register into the shift register, DI=its MSB, bit_cnt=PIX_W-1, pixels_left-1.
  - Else: DI=0, RGB_Data_Rst_Req=1.
- Prefetch: each time a pixel is loaded into the shift register and another pixel remains, issue Pix_Rd with Pix_Addr+1 on the next cycle. Capture Pix_Data 1 cycle later and set next_valid.
  - The minimum transmitter bit period exceeds 3 cycles, so next_valid is always set before it is needed.
  - If it is not set (underflow), send the stale prefetch word; no stall is required.
- Busy=1 in every state except IDLE. Frame_Start in any non-IDLE state is ignored.
- Begin_Tran_Flag stays 1 from ARM through LATCH. It drops only after RGB_Data_Rst_Tram_Ok so the transmitter can go END -> START.
- Total bits sent = 24*Num_Leds, followed by exactly one RET period. Pix_Rd count = Num_Leds.
- Num_Leds=0: the frame sends only a reset/latch period, with no Pix_Rd.
- OneBit_Tram_Ok outside SHIFT is ignored. RGB_Data_Rst_Tram_Ok outside LATCH is ignored.
- Reset mid-frame: everything returns to IDLE at once and all outputs go to 0. The transmitter shares cRst_n.
- Counter widths: bit_cnt is 5 bits and pixels_left is LED_AW bits. No wrap-around is possible within a frame.

Test Plan:
- Num_Leds=1, Pix_Data=24'hA5_0F_C3 -> DI sequence at successive sample events is 1010_0101_0000_1111_1100_0011, then RET once. Frame_Done fires 1 cycle after LATCH exit. Exactly 1 Pix_Rd, at addr 0.
- Num_Leds=3 with distinct words 24'hFF0000, 24'h00FF00, 24'h0000FF -> 72 bits in order, Pix_Addr 0,1,2. Each prefetch Pix_Rd occurs within 2 cycles of the previous pixel load.
- Num_Leds=0 -> no Pix_Rd; Begin_Tran_Flag and RGB_Data_Rst_Req both 1 before the first sample. Frame_Done after RGB_Data_Rst_Tram_Ok.
- Frame_Start pulsed again mid-frame with Num_Leds=5 during a 2-LED frame -> ignored; exactly 48 bits sent, Busy stays 1 until Frame_Done.
- cRst_n asserted during bit 10 of LED 0 -> all outputs 0 immediately. After release, a new Frame_Start runs a full correct frame from addr 0.
- Frame_Done followed immediately by Frame_Start (back-to-back frames) -> the second frame is accepted from IDLE. Begin_Tran_Flag is low for at least 1 cycle between the frames.
